video_timing_gen: RTL and testbench

- Video stream source: generates vsync/hsync/den plus an 8-bit test-pattern pixel stream.
- Drives the bypass and scaler inputs of the output mux in block-level benches and in the DUT self-test path.
- Programmable porch/sync timing, selectable pattern, clean start/stop on frame boundaries.

---
 rtl/video_timing_gen.sv | 170 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Video timing generator: programmable H/V porch/sync timing with an 8-bit test pattern.
// Outputs are registered one cycle behind the h/v counters; start/stop happen only on frame boundaries.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE      = 320,
  parameter int unsigned H_FP          = 8,
  parameter int unsigned H_SYNC        = 16,
  parameter int unsigned H_BP          = 16,
  parameter int unsigned V_ACTIVE      = 240,
  parameter int unsigned V_FP          = 2,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BP          = 4,
  parameter logic [15:0] FRAME_CNT_RST = 16'h0000
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_enable,
  input  logic [1:0]  i_pattern,
  input  logic [7:0]  i_const,
  output logic        o_vsync,
  output logic        o_hsync,
  output logic        o_den,
  output logic [7:0]  o_data,
  output logic        o_frame_start,
  output logic [15:0] o_frame_cnt,
  output logic        o_busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_LO = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_HI = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_LO = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_HI = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          stop_pending_q, stop_pending_d;
  logic [1:0]    pattern_q, pattern_d;
  logic [7:0]    const_q, const_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic          vsync_q, vsync_d;
  logic          hsync_q, hsync_d;
  logic          den_q, den_d;
  logic [7:0]    data_q, data_d;
  logic          frame_start_q, frame_start_d;
  logic          busy_q, busy_d;

  logic          run;
  logic [7:0]    x8, y8, pixel;

  always_comb begin
    state_d        = state_q;
    h_cnt_d        = h_cnt_q;
    v_cnt_d        = v_cnt_q;
    stop_pending_d = stop_pending_q;
    pattern_d      = pattern_q;
    const_d        = const_q;
    frame_cnt_d    = frame_cnt_q;

    case (state_q)
      ST_IDLE: begin
        h_cnt_d        = '0;
        v_cnt_d        = '0;
        stop_pending_d = 1'b0;
        if (i_enable) begin
          state_d   = ST_RUN;
          pattern_d = i_pattern;
          const_d   = i_const;
        end
      end
      default: begin
        stop_pending_d = ~i_enable;
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          if (v_cnt_q == V_LAST) begin
            v_cnt_d     = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            // Stop decision uses this edge's sample, so a late re-raise still keeps the stream running.
            if (stop_pending_d) begin
              state_d        = ST_IDLE;
              stop_pending_d = 1'b0;
            end else begin
              pattern_d = i_pattern;
              const_d   = i_const;
            end
          end else begin
            v_cnt_d = v_cnt_q + 1'b1;
          end
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    run = (state_q == ST_RUN);
    x8  = 8'(h_cnt_q);
    y8  = 8'(v_cnt_q);

    case (pattern_q)
      2'd0:    pixel = x8;
      2'd1:    pixel = y8;
      2'd2:    pixel = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
      default: pixel = const_q;
    endcase

    den_d         = run && (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    hsync_d       = run && (h_cnt_q >= H_SYNC_LO) && (h_cnt_q < H_SYNC_HI);
    vsync_d       = run && (v_cnt_q >= V_SYNC_LO) && (v_cnt_q < V_SYNC_HI);
    frame_start_d = run && (h_cnt_q == '0) && (v_cnt_q == '0);
    busy_d        = run;
    data_d        = den_d ? pixel : '0;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q        <= ST_IDLE;
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      stop_pending_q <= 1'b0;
      pattern_q      <= '0;
      const_q        <= '0;
      frame_cnt_q    <= FRAME_CNT_RST;
      vsync_q        <= 1'b0;
      hsync_q        <= 1'b0;
      den_q          <= 1'b0;
      data_q         <= '0;
      frame_start_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      stop_pending_q <= stop_pending_d;
      pattern_q      <= pattern_d;
      const_q        <= const_d;
      frame_cnt_q    <= frame_cnt_d;
      vsync_q        <= vsync_d;
      hsync_q        <= hsync_d;
      den_q          <= den_d;
      data_q         <= data_d;
      frame_start_q  <= frame_start_d;
      busy_q         <= busy_d;
    end
  end

  assign o_vsync       = vsync_q;
  assign o_hsync       = hsync_q;
  assign o_den         = den_q;
  assign o_data        = data_q;
  assign o_frame_start = frame_start_q;
  assign o_frame_cnt   = frame_cnt_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen using small timing parameters (16x8 cycle frames).
// A position-based reference pushes expected outputs each clock edge; scenario tasks pop and compare.
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        den;
    logic [7:0]  data;
    logic        fs;
    logic [15:0] fcnt;
    logic        busy;
  } vid_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic [7:0]  cst = 8'h00;

  logic        vsync, hsync, den, frame_start, busy;
  logic [7:0]  data;
  logic [15:0] frame_cnt;
  logic        w_vsync, w_hsync, w_den, w_frame_start, w_busy;
  logic [7:0]  w_data;
  logic [15:0] w_frame_cnt;

  vid_t act, w_act, exp, w_exp;
  vid_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .i_CLK(clk), .i_RST(rst), .i_enable(en), .i_pattern(pattern), .i_const(cst),
    .o_vsync(vsync), .o_hsync(hsync), .o_den(den), .o_data(data),
    .o_frame_start(frame_start), .o_frame_cnt(frame_cnt), .o_busy(busy)
  );

  // Same timing, frame counter preset just below its wrap point.
  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FRAME_CNT_RST(16'hFFFE)
  ) dut_wrap (
    .i_CLK(clk), .i_RST(rst), .i_enable(en), .i_pattern(pattern), .i_const(cst),
    .o_vsync(w_vsync), .o_hsync(w_hsync), .o_den(w_den), .o_data(w_data),
    .o_frame_start(w_frame_start), .o_frame_cnt(w_frame_cnt), .o_busy(w_busy)
  );

  assign act   = {vsync, hsync, den, data, frame_start, frame_cnt, busy};
  assign w_act = {w_vsync, w_hsync, w_den, w_data, w_frame_start, w_frame_cnt, w_busy};

  // Reference model: frame position 0..FRAME-1 instead of separate h/v counters.
  logic        m_run = 1'b0;
  int          m_pos = 0;
  logic [1:0]  m_pat = 2'd0;
  logic [7:0]  m_const = 8'h00;
  logic [15:0] m_fcnt = 16'h0000;
  vid_t        m_e;
  int          mh, mv;

  always @(posedge clk) begin
    m_e = '0;
    if (rst) begin
      m_run = 1'b0; m_pos = 0; m_pat = 2'd0; m_const = 8'h00; m_fcnt = 16'h0000;
      m_e.fcnt = 16'h0000;
    end else if (!m_run) begin
      m_e.fcnt = m_fcnt;
      if (en) begin
        m_run = 1'b1; m_pos = 0; m_pat = pattern; m_const = cst;
      end
    end else begin
      mh = m_pos % HT;
      mv = m_pos / HT;
      m_e.busy = 1'b1;
      m_e.fs   = (m_pos == 0);
      m_e.den  = (mh < HA) && (mv < VA);
      m_e.hs   = (mh >= HA + HF) && (mh < HA + HF + HS);
      m_e.vs   = (mv >= VA + VF) && (mv < VA + VF + VS);
      if (m_e.den) begin
        case (m_pat)
          2'd0:    m_e.data = 8'(mh);
          2'd1:    m_e.data = 8'(mv);
          2'd2:    m_e.data = (((mh >> 3) ^ (mv >> 3)) & 1) != 0 ? 8'hFF : 8'h00;
          default: m_e.data = m_const;
        endcase
      end
      if (m_pos == FRAME - 1) begin
        m_fcnt = m_fcnt + 16'd1;
        m_pos  = 0;
        if (!en) m_run = 1'b0;
        else begin
          m_pat = pattern; m_const = cst;
        end
      end else begin
        m_pos = m_pos + 1;
      end
      m_e.fcnt = m_fcnt;
    end
    sb.push_back(m_e);
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() > 0) exp = sb.pop_front();
    else exp = 'x;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (act !== exp || act !== vid_t'(0)) begin
        n_bad++;
        $display("FAIL reset cycle %0d: got %h expected %h", cyc, act, exp);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_h_ramp();
    int first_den;
    logic fs_at_first;
    first_den = -1;
    fs_at_first = 1'b0;
    pattern = 2'd0; en = 1'b1;
    for (int i = 1; i <= 2 * FRAME + 4; i++) begin
      step();
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL h_ramp cycle %0d: got %h expected %h", cyc, act, exp);
      end
      if (den === 1'b1 && first_den < 0) begin
        first_den = i;
        fs_at_first = frame_start;
      end
    end
    n_cmp++;
    if (first_den !== 2 || fs_at_first !== 1'b1) begin
      n_bad++;
      $display("FAIL first_den_latency: got %0d fs=%b expected 2 fs=1", first_den, fs_at_first);
    end
  endtask

  task automatic test_v_ramp();
    rst = 1'b1; step(); rst = 1'b0;
    pattern = 2'd1; en = 1'b1;
    for (int i = 0; i <= 2 * FRAME; i++) begin
      step();
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL v_ramp cycle %0d: got %h expected %h", cyc, act, exp);
      end
    end
    n_cmp++;
    if (frame_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL v_ramp_frame_cnt: got %0d expected 2", frame_cnt);
    end
  endtask

  task automatic test_const_switch();
    rst = 1'b1; step(); rst = 1'b0;
    pattern = 2'd3; cst = 8'hA5; en = 1'b1;
    for (int i = 0; i < 2 * FRAME + 20; i++) begin
      step();
      if (i == 50) cst = 8'h3C;
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL const_switch cycle %0d: got %h expected %h", cyc, act, exp);
      end
    end
  endtask

  task automatic test_stop();
    rst = 1'b1; step(); rst = 1'b0;
    pattern = 2'd2; en = 1'b1;
    for (int i = 0; i <= FRAME + 12; i++) begin
      step();
      if (i == 40) en = 1'b0;
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL stop cycle %0d: got %h expected %h", cyc, act, exp);
      end
    end
    n_cmp++;
    if (busy !== 1'b0 || den !== 1'b0 || frame_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL stop_idle: got busy=%b den=%b cnt=%0d expected busy=0 den=0 cnt=1", busy, den, frame_cnt);
    end
    en = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (i == 30) en = 1'b0;
      if (i == 90) en = 1'b1;
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL stop_cancel cycle %0d: got %h expected %h", cyc, act, exp);
      end
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL stop_cancel_busy: got %b expected 1", busy);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; step(); rst = 1'b0;
    pattern = 2'd0; en = 1'b1;
    for (int i = 0; i <= 70; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (act !== exp || act !== vid_t'(0)) begin
      n_bad++;
      $display("FAIL reset_mid: got %h expected %h", act, exp);
    end
    for (int i = 1; i <= 40; i++) begin
      step();
      n_cmp++;
      if (act !== exp || (i == 2 && frame_start !== 1'b1)) begin
        n_bad++;
        $display("FAIL reset_restart cycle %0d: got %h expected %h", cyc, act, exp);
      end
    end
  endtask

  task automatic test_frame_cnt_wrap();
    rst = 1'b1; step(); rst = 1'b0;
    pattern = 2'd0; en = 1'b1;
    for (int i = 0; i <= 3 * FRAME; i++) begin
      step();
      w_exp = exp;
      w_exp.fcnt = exp.fcnt + 16'hFFFE;
      n_cmp++;
      if (w_act !== w_exp) begin
        n_bad++;
        $display("FAIL frame_cnt_wrap cycle %0d: got %h expected %h", cyc, w_act, w_exp);
      end
    end
    n_cmp++;
    if (w_frame_cnt !== 16'h0001) begin
      n_bad++;
      $display("FAIL frame_cnt_wrap_final: got %h expected 0001", w_frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_h_ramp();
    test_v_ramp();
    test_const_switch();
    test_stop();
    test_reset_mid();
    test_frame_cnt_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
